// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: cathode bit order and the active-low glyph table.
package seg_pkg;

    // Cathode vector order as driven on seg_n: {g,f,e,d,c,b,a}, a in bit 0.
    typedef struct packed {
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_t;

    localparam logic [6:0] SEG_DARK = 7'h7F;

    // Active-low glyphs for 0-9 and A,b,C,d,E,F; entry 0 is in the low bits.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic seg_t glyph(input logic [3:0] value);
        return seg_t'(GLYPH_TABLE[value]);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high during the last count of each DIV-cycle period.
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner: snapshots the inputs once per frame and drives
// one digit per prescaler slot with registered active-low anodes and cathodes.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int NUMBER_OF_BITS = 4,
    parameter int REFRESH_DIV    = 100000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_DIGITS*NUMBER_OF_BITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]              dp_in,
    input  logic                               lz_en,
    input  logic                               blank,
    output logic [NUM_DIGITS-1:0]              an_n,
    output logic [6:0]                         seg_n,
    output logic                               dp_n,
    output logic                               frame_start
);

    localparam int NB    = NUMBER_OF_BITS;
    localparam int DW    = NUM_DIGITS * NB;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic                  tick;
    logic [IDX_W-1:0]      idx;
    logic                  rst_prev;
    logic                  load;
    logic [DW-1:0]         snap_digits;
    logic [NUM_DIGITS-1:0] snap_dp;
    logic                  snap_lz;

    tick_gen #(
        .DIV (REFRESH_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign load        = !rst && (rst_prev || (tick && idx == LAST_IDX));
    assign frame_start = load;

    always_ff @(posedge clk) begin
        rst_prev <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_lz     <= 1'b0;
        end else if (load) begin
            snap_digits <= digits_in;
            snap_dp     <= dp_in;
            snap_lz     <= lz_en;
        end
    end

    // On the load cycle right after reset the snapshot register still holds zeros,
    // so digit 0 is decoded straight from the inputs being captured.
    logic [DW-1:0]         src_digits;
    logic [NUM_DIGITS-1:0] src_dp;
    logic                  src_lz;

    assign src_digits = rst_prev ? digits_in : snap_digits;
    assign src_dp     = rst_prev ? dp_in     : snap_dp;
    assign src_lz     = rst_prev ? lz_en     : snap_lz;

    logic [NUM_DIGITS-1:0] zero_from;
    logic [NB-1:0]         cur_digit;
    logic                  over_range;
    logic                  lz_blank;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    always_comb begin
        // zero_from[i] is set when digits i..NUM_DIGITS-1 are all zero.
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (src_digits[(NUM_DIGITS-1)*NB +: NB] == '0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (src_digits[i*NB +: NB] == '0);
        end

        cur_digit  = src_digits[idx*NB +: NB];
        over_range = (NB > 4) && ((cur_digit >> 4) != '0);
        lz_blank   = src_lz && (idx != '0) && zero_from[idx];

        seg_next = (over_range || lz_blank) ? SEG_DARK : glyph(4'(cur_digit));
        an_next  = ~(NUM_DIGITS'(1) << idx);
        dp_next  = ~src_dp[idx];
    end

    always_ff @(posedge clk) begin
        if (rst || blank) begin
            an_n  <= '1;
            seg_n <= SEG_DARK;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= an_next;
            seg_n <= seg_next;
            dp_n  <= dp_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed checks of seg_scan_driver against a frame-level reference model.
module tb_seg_scan_driver;

    localparam int NUM_DIGITS = 4;
    localparam int NB         = 4;
    localparam int DIV        = 4;
    localparam int FR         = DIV * NUM_DIGITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        lz_en = 1'b0;
    logic        blank = 1'b0;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_start;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .NUM_DIGITS     (NUM_DIGITS),
        .NUMBER_OF_BITS (NB),
        .REFRESH_DIV    (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .lz_en       (lz_en),
        .blank       (blank),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: cycle t counts from reset release; frame f is captured at cycle
    // 0 (f=0) or FR*f-1, and the output in cycle t shows position t-1.
    int          last_t = -1;
    int          cur_t = -1;
    logic        prev_rst = 1'b1;
    logic        prev_blank = 1'b0;
    logic [15:0] snap_d_q[$];
    logic [3:0]  snap_p_q[$];
    logic        snap_l_q[$];
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fs;

    task automatic model_step();
        int p, f, i, v;
        logic [15:0] d;
        logic [3:0] dps;
        cur_t  = rst ? -1 : last_t + 1;
        exp_fs = !rst && (cur_t == 0 || (cur_t % FR) == FR - 1);
        if (prev_rst || prev_blank) begin
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            p   = last_t;
            f   = p / FR;
            i   = (p / DIV) % NUM_DIGITS;
            d   = snap_d_q[f];
            dps = snap_p_q[f];
            v   = int'((d >> (4 * i)) & 16'hF);
            exp_an    = 4'hF;
            exp_an[i] = 1'b0;
            if (snap_l_q[f] && i > 0 && (d >> (4 * i)) == 16'h0) exp_seg = 7'h7F;
            else exp_seg = glyph_ref[v];
            exp_dp = ~dps[i];
        end
        if (rst) begin
            snap_d_q.delete();
            snap_p_q.delete();
            snap_l_q.delete();
        end else if (exp_fs) begin
            snap_d_q.push_back(digits_in);
            snap_p_q.push_back(dp_in);
            snap_l_q.push_back(lz_en);
        end
        prev_rst   = rst;
        prev_blank = blank;
        last_t     = cur_t;
    endtask

    task automatic test_reset();
        logic [3:0] an_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst = 1'b1;
        @(negedge clk); #1; model_step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1; model_step();
            checks++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL reset_hold t=%0d got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                         cur_t, an_n, seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
        end
        @(negedge clk);
        rst = 1'b0; digits_in = 16'h1234; dp_in = 4'h0; lz_en = 1'b0;
        #1; model_step();
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL release_frame_start got %b exp 1", frame_start);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); #1; model_step();
            checks++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL release_scan t=%0d got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                         cur_t, an_n, seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (k == 1) begin
                checks++;
                if (seg_n !== 7'b0011001) begin
                    errors++;
                    $display("FAIL release_glyph4 got %b exp 0011001", seg_n);
                end
            end
            if ((k - 1) % 4 == 0) begin
                checks++;
                if (an_n !== an_seq[(k-1)/4]) begin
                    errors++;
                    $display("FAIL release_an_seq k=%0d got %b exp %b", k, an_n, an_seq[(k-1)/4]);
                end
            end
        end
    endtask

    task automatic test_lz_blanking();
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 48; k++) begin
                @(negedge clk);
                if (k == 0) begin
                    digits_in = 16'h0070; dp_in = 4'h0; lz_en = (pass == 0);
                end
                #1; model_step();
                checks++;
                if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                    errors++;
                    $display("FAIL lz_scan t=%0d got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                             cur_t, an_n, seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
                end
                if (k >= 32) begin
                    checks++;
                    if ((an_n == 4'b0111 || an_n == 4'b1011) && seg_n !== (pass == 0 ? 7'h7F : 7'h40)) begin
                        errors++;
                        $display("FAIL lz_upper pass=%0d an=%b got %b", pass, an_n, seg_n);
                    end else if (an_n == 4'b1101 && seg_n !== 7'b1111000) begin
                        errors++;
                        $display("FAIL lz_digit1 pass=%0d got %b exp 1111000", pass, seg_n);
                    end else if (an_n == 4'b1110 && seg_n !== 7'b1000000) begin
                        errors++;
                        $display("FAIL lz_digit0 pass=%0d got %b exp 1000000", pass, seg_n);
                    end
                end
            end
        end
    endtask

    task automatic test_snapshot();
        int k = 0;
        digits_in = 16'h1111; dp_in = 4'h0; lz_en = 1'b0;
        for (int n = 0; n < 32 || (n < 48 && (cur_t % FR) != 3); n++) begin
            @(negedge clk); #1; model_step();
            checks++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL snap_fill t=%0d got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                         cur_t, an_n, seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
        end
        checks++;
        if ((cur_t % FR) != 3) begin
            errors++;
            $display("FAIL snap_align got phase %0d exp 3", cur_t % FR);
        end
        for (k = 0; k <= 28; k++) begin
            @(negedge clk);
            if (k == 0) digits_in = 16'h2222;
            #1; model_step();
            checks++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL snap_scan t=%0d got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                         cur_t, an_n, seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            checks++;
            if (k <= 12 && seg_n !== 7'b1111001) begin
                errors++;
                $display("FAIL snap_old k=%0d got %b exp 1111001", k, seg_n);
            end else if (k >= 13 && seg_n !== 7'b0100100) begin
                errors++;
                $display("FAIL snap_new k=%0d got %b exp 0100100", k, seg_n);
            end
        end
    endtask

    task automatic test_hex_dp_blank();
        logic [6:0] hex_ref [4] = '{7'b0001110, 7'b1000110, 7'b0000011, 7'b0001000};
        digits_in = 16'hABCF; dp_in = 4'b0100; lz_en = 1'b0;
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            if (k == 48) blank = 1'b1;
            if (k == 60) blank = 1'b0;
            #1; model_step();
            checks++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL hex_scan t=%0d got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                         cur_t, an_n, seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (k >= 32 && k < 48) begin
                for (int i = 0; i < 4; i++) begin
                    if (an_n[i] == 1'b0) begin
                        checks++;
                        if (seg_n !== hex_ref[i] || dp_n !== (i != 2)) begin
                            errors++;
                            $display("FAIL hex_glyph i=%0d got seg=%b dp=%b exp seg=%b dp=%b",
                                     i, seg_n, dp_n, hex_ref[i], (i != 2));
                        end
                    end
                end
            end
            if (k >= 49 && k <= 60) begin
                checks++;
                if ({an_n, seg_n, dp_n} !== 12'hFFF) begin
                    errors++;
                    $display("FAIL blank_dark k=%0d got an=%b seg=%b dp=%b exp all ones", k, an_n, seg_n, dp_n);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int n = 0; n < 16 && (cur_t % FR) != 7; n++) begin
            @(negedge clk); #1; model_step();
            checks++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL mid_align t=%0d got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                         cur_t, an_n, seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
        end
        digits_in = 16'h5678; dp_in = 4'b0001;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            rst = (k == 0);
            #1; model_step();
            checks++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL mid_scan k=%0d got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                         k, an_n, seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
            if (k == 1) begin
                checks++;
                if ({an_n, seg_n, dp_n, frame_start} !== 13'h1FFF) begin
                    errors++;
                    $display("FAIL mid_after_rst got an=%b seg=%b dp=%b fs=%b exp all ones fs=1",
                             an_n, seg_n, dp_n, frame_start);
                end
            end
            if (k == 2) begin
                checks++;
                if (an_n !== 4'b1110 || seg_n !== 7'b0000000) begin
                    errors++;
                    $display("FAIL mid_restart got an=%b seg=%b exp an=1110 seg=0000000", an_n, seg_n);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                digits_in = 16'($urandom);
                dp_in     = 4'($urandom);
                lz_en     = 1'($urandom);
            end
            if ($urandom_range(0, 29) == 0) blank = ~blank;
            rst = ($urandom_range(0, 149) == 0);
            #1; model_step();
            checks++;
            if ({an_n, seg_n, dp_n, frame_start} !== {exp_an, exp_seg, exp_dp, exp_fs}) begin
                errors++;
                $display("FAIL random t=%0d got an=%b seg=%b dp=%b fs=%b exp an=%b seg=%b dp=%b fs=%b",
                         cur_t, an_n, seg_n, dp_n, frame_start, exp_an, exp_seg, exp_dp, exp_fs);
            end
        end
        @(negedge clk);
        rst = 1'b0; blank = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lz_blanking();
        test_snapshot();
        test_hex_dp_blank();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed seven-segment digits.
REQ-002 SHALL have parameter NUMBER_OF_BITS, default 4, width of one digit value.
REQ-003 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot; legal range 2 or more.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port digits_in  input  NUM_DIGITS*NUMBER_OF_BITS  digit values, digit 0 (rightmost) in the LSBs.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal point request per digit, bit i = digit i.
REQ-008 SHALL have port lz_en  input  1  leading-zero blanking enable.
REQ-009 SHALL have port blank  input  1  forces the display dark.
REQ-010 SHALL have port an_n  output  NUM_DIGITS  active-low digit anodes.
REQ-011 SHALL have port seg_n  output  7  active-low cathodes, ordered {g,f,e,d,c,b,a}.
REQ-012 SHALL have port dp_n  output  1  active-low decimal point cathode.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse when a new snapshot is loaded.

Function
REQ-014 SHALL run a prescaler counting 0..REFRESH_DIV-1, then wrapping to 0; tick is asserted while the count equals REFRESH_DIV-1.
REQ-015 SHALL hold scan index idx in 0..NUM_DIGITS-1; on tick, idx advances by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-016 SHALL load snapshot registers (digits_in, dp_in, lz_en) on a tick with idx==NUM_DIGITS-1, and on the first cycle after rst deasserts; frame_start SHALL pulse on exactly those cycles.
REQ-017 SHALL display only snapshot values; input changes mid-frame SHALL NOT affect the current frame.
REQ-018 SHALL register an_n, seg_n and dp_n; they reflect idx and the snapshot with one cycle of latency.
REQ-019 SHALL drive an_n with only bit idx low when displaying; all other bits SHALL be high.
REQ-020 SHALL decode values 0-9 as decimal glyphs and 10-15 as hex glyphs A,b,C,d,E,F; examples: 0=1000000, 1=1111001, 8=0000000, F=0001110.
REQ-021 SHALL blank digit i (seg_n all 1) when snapshot lz_en=1, i>0, and all snapshot digits i..NUM_DIGITS-1 are zero; digit 0 SHALL never be zero-blanked.
REQ-022 SHALL drive dp_n low when snapshot dp bit idx=1, including on a zero-blanked digit.
REQ-023 SHALL, while blank=1, drive an_n, seg_n and dp_n to all ones one cycle after blank rises; prescaler, idx and snapshot loading SHALL continue unaffected.
REQ-024 SHALL ignore bits above NUMBER_OF_BITS; for NUMBER_OF_BITS>4, values above 15 SHALL display as dark segments.

Reset
REQ-025 SHALL, while rst=1, clear prescaler, idx and snapshot to 0; drive an_n, seg_n and dp_n to all ones; and drive frame_start to 0.
REQ-026 SHALL override all other activity with rst in the same cycle, including a tick or a snapshot load; a mid-frame rst SHALL restart the scan at idx 0.

Structure
REQ-027 SHALL place the 16-entry glyph table constant and the segment bit-order definition in shared package seg_pkg.
REQ-028 SHALL implement the prescaler as sub-module tick_gen (parameter DIV, ports clk, rst, tick).
REQ-029 SHALL keep the glyph decode and leading-zero logic combinational inside seg_scan_driver, feeding the output registers.

Verification (REFRESH_DIV=4, NUM_DIGITS=4)
REQ-030 SHALL check reset release with digits_in=0x1234 -> frame_start pulses on the first cycle; from the next cycle an_n=1110 and seg_n=glyph 4; idx advances every 4 cycles; an_n sequence is 1110, 1101, 1011, 0111, 1110.
REQ-031 SHALL check leading-zero blanking with digits_in=0x0070, lz_en=1 -> digits 3 and 2 dark, digit 1 shows 7, digit 0 shows 0; with lz_en=0, all four digits show their values.
REQ-032 SHALL check snapshot integrity: change digits_in from 0x1111 to 0x2222 while idx=1 -> digits 1-3 still show 1 in that frame; 2 appears only after the next frame_start.
REQ-033 SHALL check hex, decimal point and blank: digits_in=0xABCF with dp_in=0100 -> glyphs F, C, b, A and dp_n low only at idx=2; raising blank -> all outputs go to 1 after 1 cycle while idx keeps advancing.
REQ-034 SHALL check mid-frame reset: assert rst for 1 cycle at idx=2 -> the next cycle shows outputs all ones; scanning restarts at idx 0 with a fresh frame_start.
